// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the sequential ALU front-end: the 6-bit opcode
// encodings, the load-order FSM state type and the opcode legality check.
// No ports; imported by alu_core and alu_seq_ff.

package alu_pkg;

  // Opcode field width; the opcode is always taken from entrada[5:0].
  localparam int OPW = 6;

  localparam logic [OPW-1:0] OP_ADD = 6'b100000;
  localparam logic [OPW-1:0] OP_SUB = 6'b100010;
  localparam logic [OPW-1:0] OP_AND = 6'b100100;
  localparam logic [OPW-1:0] OP_OR  = 6'b100101;
  localparam logic [OPW-1:0] OP_XOR = 6'b100110;
  localparam logic [OPW-1:0] OP_NOR = 6'b100111;
  localparam logic [OPW-1:0] OP_SRL = 6'b000010;
  localparam logic [OPW-1:0] OP_SRA = 6'b000011;

  // Operands and opcode must be loaded in this order after reset.
  typedef enum logic [1:0] {
    WAIT_A  = 2'd0,
    WAIT_B  = 2'd1,
    WAIT_OP = 2'd2,
    READY   = 2'd3
  } state_t;

  // True only for the eight supported opcodes.
  function automatic logic is_legal_op(input logic [OPW-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRL, OP_SRA: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core
// Purely combinational ALU datapath.
// Ports:
//   a, b      in  W   operands
//   op        in  6   function code
//   result    out W   operation result (modulo 2^W)
//   carry     out 1   adder carry-out for ADD/SUB (SUB: 1 = no borrow), else 0
//   overflow  out 1   signed overflow for ADD/SUB, else 0
//   legal     out 1   op is one of the supported opcodes

module alu_core
  import alu_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [OPW-1:0] op,
  output logic [W-1:0]   result,
  output logic           carry,
  output logic           overflow,
  output logic           legal
);

  logic         sub;
  logic [W-1:0] bop;
  logic [W:0]   sum;
  logic [SHW-1:0] sh;

  // One shared adder serves ADD and SUB: subtraction is A + ~B + 1, so the
  // carry-out directly reads as "no borrow".
  always_comb begin
    sub = (op == OP_SUB);
    bop = sub ? ~b : b;
    sum = {1'b0, a} + {1'b0, bop} + {{W{1'b0}}, sub};
    sh  = b[SHW-1:0];
  end

  // Result mux; logic and shift operations never report carry or overflow.
  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result   = sum[W-1:0];
        carry    = sum[W];
        overflow = (a[W-1] == bop[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      OP_SRL: result = a >> sh;
      OP_SRA: result = W'($signed(a) >>> sh);
      default: result = '0;
    endcase
  end

  always_comb begin
    legal = is_legal_op(op);
  end

endmodule

// File: rtl/alu_seq_ff.sv
// alu_seq_ff
// Registered ALU front-end. A, B and the opcode are loaded in order from the
// shared bus under three push-button strobes; once all three are loaded the
// result and status flags are registered one cycle after every load.
// Ports:
//   clk       in  1   clock, rising edge
//   reset     in  1   synchronous active-high reset
//   entrada   in  W   shared load bus (opcode = entrada[5:0])
//   b1,b2,b3  in  1   load-A / load-B / load-opcode strobes (level inputs)
//   result    out W   registered result
//   valid     out 1   A, B and opcode have all been loaded since reset
//   zero      out 1   result == 0
//   negative  out 1   result MSB
//   carry     out 1   ADD/SUB carry-out
//   overflow  out 1   ADD/SUB signed overflow
//   err       out 1   most recent opcode load was illegal

module alu_seq_ff
  import alu_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] entrada,
  input  logic         b1,
  input  logic         b2,
  input  logic         b3,
  output logic [W-1:0] result,
  output logic         valid,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow,
  output logic         err
);

  // Number of bus bits that carry the opcode (narrow builds zero-extend).
  localparam int OPN = (W < OPW) ? W : OPW;

  state_t         state;
  logic [W-1:0]   a_reg;
  logic [W-1:0]   b_reg;
  logic [OPW-1:0] op_reg;
  logic [2:0]     hist;
  logic [2:0]     armed;
  logic           recompute;

  logic [2:0]     bvec;
  logic [2:0]     rise;
  logic           sel_a, sel_b, sel_op;
  logic           ld_a, ld_b, ld_op;
  logic [OPW-1:0] op_in;

  logic [W-1:0]   core_result;
  logic           core_carry;
  logic           core_overflow;
  logic           core_legal;

  // A press needs a low-to-high transition. The armed bits additionally
  // require that a button has been seen low since reset, so a button held
  // through reset is not mistaken for a fresh press when reset releases.
  always_comb begin
    bvec   = {b3, b2, b1};
    rise   = bvec & ~hist & armed;
    sel_a  = rise[0];
    sel_b  = rise[1] & ~rise[0];
    sel_op = rise[2] & ~rise[1] & ~rise[0];
  end

  // Priority is resolved first, then the FSM decides whether the winning
  // press is accepted in the current state.
  always_comb begin
    ld_a  = sel_a  && ((state == WAIT_A)  || (state == READY));
    ld_b  = sel_b  && ((state == WAIT_B)  || (state == READY));
    ld_op = sel_op && ((state == WAIT_OP) || (state == READY));
  end

  always_comb begin
    op_in          = '0;
    op_in[OPN-1:0] = entrada[OPN-1:0];
  end

  alu_core #(
    .W   (W),
    .SHW (SHW)
  ) u_core (
    .a        (a_reg),
    .b        (b_reg),
    .op       (op_reg),
    .result   (core_result),
    .carry    (core_carry),
    .overflow (core_overflow),
    .legal    (core_legal)
  );

  // Strobe history, load-order FSM and operand registers. recompute marks
  // that a load landed this edge and the output stage must refresh next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= WAIT_A;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      hist      <= '0;
      armed     <= ~bvec;
      recompute <= 1'b0;
    end else begin
      hist  <= bvec;
      armed <= armed | ~bvec;

      if (ld_a)  a_reg  <= entrada;
      if (ld_b)  b_reg  <= entrada;
      if (ld_op) op_reg <= op_in;

      case (state)
        WAIT_A:  if (ld_a)  state <= WAIT_B;
        WAIT_B:  if (ld_b)  state <= WAIT_OP;
        WAIT_OP: if (ld_op) state <= READY;
        default: state <= READY;
      endcase

      recompute <= (ld_op && (state == WAIT_OP)) ||
                   ((state == READY) && (ld_a || ld_b || ld_op));
    end
  end

  // Output stage. An illegal opcode raises err but leaves the result and all
  // flags untouched, so they keep showing the last legal computation.
  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      valid    <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      err      <= 1'b0;
    end else if (recompute) begin
      valid <= 1'b1;
      err   <= ~core_legal;
      if (core_legal) begin
        result   <= core_result;
        zero     <= (core_result == '0);
        negative <= core_result[W-1];
        carry    <= core_carry;
        overflow <= core_overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_ff.sv
// tb_alu_seq_ff
// Directed bench for alu_seq_ff (W=8) with an arithmetic reference model
// compared against the DUT outputs every cycle, plus literal spot checks.

module tb_alu_seq_ff;
  import alu_pkg::*;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] entrada = '0;
  logic         b1 = 1'b0;
  logic         b2 = 1'b0;
  logic         b3 = 1'b0;
  logic [W-1:0] result;
  logic         valid, zero, negative, carry, overflow, err;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  alu_seq_ff #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .entrada  (entrada),
    .b1       (b1),
    .b2       (b2),
    .b3       (b3),
    .result   (result),
    .valid    (valid),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference model state: loaded values, how many loads the sequence has
  // completed (0..3), and the expected registered outputs.
  int   ma = 0, mb = 0, mop = 0, mphase = 0;
  bit   mpend = 0;
  bit [2:0] mprev = 0, marm = 0, bv = 0, rises = 0;
  int   which = 0;
  int   e_result = 0;
  bit   e_valid = 0, e_zero = 0, e_neg = 0, e_carry = 0, e_ovf = 0, e_err = 0;
  int   r_tmp = 0;
  bit   c_tmp = 0, v_tmp = 0, ok_tmp = 0;

  function automatic int to_signed(input int x);
    return (x >= HALF) ? x - (1 << W) : x;
  endfunction

  // Operation semantics in plain integer arithmetic.
  function automatic void model_alu(input int a, input int b, input int op,
                                    output int r, output bit c, output bit v,
                                    output bit ok);
    int s;
    int ss;
    int sh;
    r = 0; c = 0; v = 0; ok = 1;
    sh = b % W;
    case (op)
      32: begin
        s  = a + b;
        r  = s & MASK;
        c  = (s > MASK);
        ss = to_signed(a) + to_signed(b);
        v  = (ss >= HALF) || (ss < -HALF);
      end
      34: begin
        s  = a - b;
        r  = s & MASK;
        c  = (a >= b);
        ss = to_signed(a) - to_signed(b);
        v  = (ss >= HALF) || (ss < -HALF);
      end
      36: r = a & b;
      37: r = a | b;
      38: r = a ^ b;
      39: r = ~(a | b) & MASK;
      2:  r = a >> sh;
      3:  r = (to_signed(a) >>> sh) & MASK;
      default: ok = 0;
    endcase
  endfunction

  always @(posedge clk) begin
    bv = {b3, b2, b1};
    if (reset) begin
      ma = 0; mb = 0; mop = 0; mphase = 0; mpend = 0;
      mprev = 0; marm = ~bv;
      e_result = 0; e_valid = 0; e_zero = 0; e_neg = 0;
      e_carry = 0; e_ovf = 0; e_err = 0;
    end else begin
      if (mpend) begin
        model_alu(ma, mb, mop, r_tmp, c_tmp, v_tmp, ok_tmp);
        e_valid = 1;
        e_err   = !ok_tmp;
        if (ok_tmp) begin
          e_result = r_tmp;
          e_zero   = (r_tmp == 0);
          e_neg    = (r_tmp >= HALF);
          e_carry  = c_tmp;
          e_ovf    = v_tmp;
        end
      end
      mpend = 0;
      rises = bv & ~mprev & marm;
      which = rises[0] ? 1 : rises[1] ? 2 : rises[2] ? 3 : 0;
      if (which != 0 && (mphase == 3 || which == mphase + 1)) begin
        if (which == 1) ma = int'(entrada);
        if (which == 2) mb = int'(entrada);
        if (which == 3) mop = int'(entrada) & 63;
        if (mphase >= 2) mpend = 1;
        if (mphase < 3) mphase = mphase + 1;
      end
      mprev = bv;
      marm  = marm | ~bv;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (run) begin
      checks = checks + 1;
      if ({result, valid, zero, negative, carry, overflow, err} !==
          {e_result[W-1:0], e_valid, e_zero, e_neg, e_carry, e_ovf, e_err}) begin
        errors = errors + 1;
        $display("[TB] FAIL model_cycle t=%0t got res=%h v%b z%b n%b c%b o%b e%b want res=%h v%b z%b n%b c%b o%b e%b",
                 $time, result, valid, zero, negative, carry, overflow, err,
                 e_result[W-1:0], e_valid, e_zero, e_neg, e_carry, e_ovf, e_err);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // One press: strobe high for one cycle, then one idle cycle. On return the
  // result for that press is visible.
  task automatic applyStimulus(input int btn, input logic [W-1:0] val);
    @(negedge clk);
    entrada = val;
    b1 = (btn == 1);
    b2 = (btn == 2);
    b3 = (btn == 3);
    @(negedge clk);
    b1 = 0; b2 = 0; b3 = 0;
    entrada = 8'hA5;
    @(negedge clk);
  endtask

  // {valid, zero, negative, carry, overflow, err}
  function automatic logic [31:0] flags();
    return {26'd0, valid, zero, negative, carry, overflow, err};
  endfunction

  initial begin
    reset = 1;
    repeat (2) @(negedge clk);
    checkOutput("reset_result", 32'(result), 32'h00);
    checkOutput("reset_flags", flags(), 32'b000000);
    checkOutput("reset_state", 32'(dut.state), 32'(WAIT_A));
    run = 1;
    reset = 0;

    applyStimulus(2, 8'h99);
    checkOutput("b2_in_wait_a", 32'(dut.state), 32'(WAIT_A));

    @(negedge clk);
    entrada = 8'h07; b1 = 1;
    @(negedge clk);
    entrada = 8'h55;
    repeat (4) @(negedge clk);
    b1 = 0;
    @(negedge clk);
    checkOutput("held_b1_state", 32'(dut.state), 32'(WAIT_B));

    applyStimulus(2, 8'h03);
    applyStimulus(3, 8'h20);
    checkOutput("add_result", 32'(result), 32'h0A);
    checkOutput("add_flags", flags(), 32'b100000);

    @(negedge clk);
    entrada = 8'h07; b1 = 1;
    @(negedge clk);
    entrada = 8'h55;
    repeat (4) @(negedge clk);
    b1 = 0;
    @(negedge clk);
    checkOutput("held_b1_ready", 32'(result), 32'h0A);

    applyStimulus(3, 8'h22);
    checkOutput("sub_fwd_result", 32'(result), 32'h04);
    checkOutput("sub_fwd_carry", 32'(carry), 32'd1);
    applyStimulus(1, 8'h03);
    applyStimulus(2, 8'h07);
    checkOutput("sub_rev_result", 32'(result), 32'hFC);
    checkOutput("sub_rev_flags", flags(), 32'b101000);

    applyStimulus(1, 8'h7F);
    applyStimulus(2, 8'h01);
    applyStimulus(3, 8'h20);
    checkOutput("ovf_result", 32'(result), 32'h80);
    checkOutput("ovf_flags", flags(), 32'b101010);
    applyStimulus(1, 8'h80);
    applyStimulus(2, 8'h03);
    applyStimulus(3, 8'h03);
    checkOutput("sra_result", 32'(result), 32'hF0);
    applyStimulus(3, 8'h02);
    checkOutput("srl_result", 32'(result), 32'h10);
    checkOutput("srl_flags", flags(), 32'b100000);

    applyStimulus(3, 8'h3F);
    checkOutput("illegal_result", 32'(result), 32'h10);
    checkOutput("illegal_err", 32'(err), 32'd1);
    applyStimulus(1, 8'h0F);
    checkOutput("illegal_a_hold", 32'(result), 32'h10);
    applyStimulus(2, 8'h3C);
    applyStimulus(3, 8'h24);
    checkOutput("and_result", 32'(result), 32'h0C);
    checkOutput("and_err", 32'(err), 32'd0);

    @(negedge clk);
    entrada = 8'hFF; b1 = 1; b2 = 1;
    @(negedge clk);
    b1 = 0; b2 = 0;
    @(negedge clk);
    checkOutput("b1b2_priority", 32'(result), 32'h3C);

    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    applyStimulus(1, 8'h05);
    applyStimulus(2, 8'h06);
    checkOutput("pre_reset_state", 32'(dut.state), 32'(WAIT_OP));
    @(negedge clk);
    entrada = 8'h20; b3 = 1; reset = 1;
    @(negedge clk);
    reset = 0;
    checkOutput("midreset_result", 32'(result), 32'h00);
    checkOutput("midreset_flags", flags(), 32'b000000);
    checkOutput("midreset_state", 32'(dut.state), 32'(WAIT_A));
    repeat (3) @(negedge clk);
    checkOutput("midreset_b3_held", 32'(dut.state), 32'(WAIT_A));

    b3 = 0; b1 = 1; entrada = 8'h11; reset = 1;
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_b1_held", 32'(dut.state), 32'(WAIT_A));
    b1 = 0;
    @(negedge clk);

    applyStimulus(1, 8'h05);
    checkOutput("rearm_b1", 32'(dut.state), 32'(WAIT_B));
    applyStimulus(2, 8'h06);
    applyStimulus(3, 8'h3F);
    checkOutput("illegal_first_result", 32'(result), 32'h00);
    checkOutput("illegal_first_flags", flags(), 32'b100001);
    applyStimulus(3, 8'h20);
    checkOutput("final_add", 32'(result), 32'h0B);

    repeat (2) @(negedge clk);
    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
